mostrador: RTL

MOSTRADOR -- requirements
Module: mostrador

---
 rtl/mostrador_if.sv | 21 ++
 rtl/mostrador.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mostrador_if.sv
// Bus between the ALU side and the result display: ALU result/flags and capture button in,
// multiplexed 7-segment drive and capture strobe out.
interface mostrador_if;
    logic [7:0] resultado;
    logic       carry;
    logic       zero;
    logic       boton_res;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       capturado;

    modport master (
        output resultado, carry, zero, boton_res,
        input  anodos, segmentos, capturado
    );

    modport slave (
        input  resultado, carry, zero, boton_res,
        output anodos, segmentos, capturado
    );
endinterface

// File: rtl/mostrador.sv
// Captures the ALU result on a debounced button press and shows it on a 4-digit,
// active-low multiplexed 7-segment display: result low/high nibble, carry, zero.
module mostrador #(
    parameter int DEB_CICLOS      = 500000,
    parameter int REFRESCO_CICLOS = 50000
) (
    input logic       clk,
    input logic       reset,
    mostrador_if.slave bus
);
    localparam int DEB_W = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam int REF_W = (REFRESCO_CICLOS > 1) ? $clog2(REFRESCO_CICLOS) : 1;

    typedef enum logic {VACIO, MOSTRANDO} estado_t;

    estado_t          estado, estado_d;
    logic             sync_0, sync_1;
    logic             estable;
    logic [DEB_W-1:0] cnt_deb;
    logic             sube;
    logic [REF_W-1:0] cnt_ref;
    logic [1:0]       indice;
    logic [7:0]       res_q;
    logic             carry_q, zero_q;
    logic             capturado_q;
    logic [3:0]       anodos_q, anodos_d;
    logic [6:0]       segmentos_q, segmentos_d;
    logic [3:0]       digito;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            estable <= 1'b0;
            cnt_deb <= '0;
        end else begin
            sync_0 <= bus.boton_res;
            sync_1 <= sync_0;
            if (sync_1 != estable) begin
                if (cnt_deb == DEB_W'(DEB_CICLOS - 1)) begin
                    estable <= sync_1;
                    cnt_deb <= '0;
                end else begin
                    cnt_deb <= cnt_deb + DEB_W'(1);
                end
            end else begin
                cnt_deb <= '0;
            end
        end
    end

    // Capture fires on the very edge where the stable level rises, so no extra edge-detect flop.
    assign sube = sync_1 && !estable && (cnt_deb == DEB_W'(DEB_CICLOS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q       <= 8'h00;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            capturado_q <= 1'b0;
        end else begin
            capturado_q <= sube;
            if (sube) begin
                res_q   <= bus.resultado;
                carry_q <= bus.carry;
                zero_q  <= bus.zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= VACIO;
        end else begin
            estado <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado;
        case (estado)
            VACIO:     if (sube) estado_d = MOSTRANDO;
            MOSTRANDO: estado_d = MOSTRANDO;
            default:   estado_d = VACIO;
        endcase
    end

    // Multiplexing runs free once showing; a new capture does not restart it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ref <= '0;
            indice  <= 2'd0;
        end else if (estado == MOSTRANDO) begin
            if (cnt_ref == REF_W'(REFRESCO_CICLOS - 1)) begin
                cnt_ref <= '0;
                indice  <= indice + 2'd1;
            end else begin
                cnt_ref <= cnt_ref + REF_W'(1);
            end
        end
    end

    always_comb begin
        anodos_d    = 4'b1111;
        segmentos_d = 7'b1111111;
        digito      = 4'h0;
        if (estado == MOSTRANDO) begin
            case (indice)
                2'd0: begin anodos_d = 4'b1110; digito = res_q[3:0];        end
                2'd1: begin anodos_d = 4'b1101; digito = res_q[7:4];        end
                2'd2: begin anodos_d = 4'b1011; digito = {3'b000, carry_q}; end
                default: begin anodos_d = 4'b0111; digito = {3'b000, zero_q}; end
            endcase
            segmentos_d = hex7(digito);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anodos_q    <= 4'b1111;
            segmentos_q <= 7'b1111111;
        end else begin
            anodos_q    <= anodos_d;
            segmentos_q <= segmentos_d;
        end
    end

    assign bus.anodos    = anodos_q;
    assign bus.segmentos = segmentos_q;
    assign bus.capturado = capturado_q;
endmodule
